// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the MEM/WB stage: state encoding, opcodes and address helpers.
package data_mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } stage_state_e;

    localparam logic [5:0]  OP_LW             = 6'd35;
    localparam logic [5:0]  OP_SW             = 6'd43;
    localparam logic [31:0] WORD_ALIGN_MASK   = 32'h0000_0003;
    localparam int          DEFAULT_MEM_BYTES = 1024;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & WORD_ALIGN_MASK) != 32'd0;
    endfunction

endpackage

// File: rtl/data_mem_stage_memory.sv
// Byte-addressed big-endian data memory: synchronous word write, combinational word read.
// Contents are deliberately not reset.
module data_memory_array
    import data_mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-3:0] word_idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] a0, a1, a2, a3;

    // Most significant byte lives at the lowest address.
    assign a0 = {word_idx, 2'b00};
    assign a1 = {word_idx, 2'b01};
    assign a2 = {word_idx, 2'b10};
    assign a3 = {word_idx, 2'b11};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a0] <= wdata[31:24];
            mem[a1] <= wdata[23:16];
            mem[a2] <= wdata[15:8];
            mem[a3] <= wdata[7:0];
        end
    end

    assign rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};

endmodule

// File: rtl/data_mem_stage.sv
// MEM/WB stage: captures one ALU result plus control, performs LW/SW with a fixed
// wait latency, and presents a one-cycle writeback to the register file.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int ACCESS_LAT = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  ALUOut,
    input  logic [31:0]  B,
    input  logic [4:0]   WriteReg_in,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         MemtoReg,
    input  logic         RegWrite_in,
    output logic [31:0]  WriteData,
    output logic [4:0]   WriteReg,
    output logic         RegWrite,
    output logic         wb_valid,
    output logic         mem_fault,
    output stage_state_e state_dbg
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    // Handshake: a transaction transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only in IDLE with RESET low; inputs are ignored otherwise.

    stage_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       wreg_q, wreg_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             memtoreg_q, memtoreg_d;
    logic             regwrite_in_q, regwrite_in_d;
    logic             fault_q, fault_d;
    logic [31:0]      load_q, load_d;
    logic [31:0]      write_data_q, write_data_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic             reg_write_q, reg_write_d;
    logic             wb_valid_q, wb_valid_d;
    logic             mem_fault_q, mem_fault_d;

    logic             mem_we;
    logic [31:0]      mem_rdata;
    logic             mem_op;
    logic             fault_now;

    assign in_ready  = (state_q == ST_IDLE) && !RESET;
    assign mem_op    = MemRead || MemWrite;
    assign fault_now = (mem_op && (is_misaligned(ALUOut) || (ALUOut >= 32'(MEM_BYTES))))
                     || (MemRead && MemWrite);

    data_memory_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk      (CLK),
        .we       (mem_we),
        .word_idx (addr_q[AW-1:2]),
        .wdata    (b_q),
        .rdata    (mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        b_d           = b_q;
        wreg_d        = wreg_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        memtoreg_d    = memtoreg_q;
        regwrite_in_d = regwrite_in_q;
        fault_d       = fault_q;
        load_d        = load_q;
        write_data_d  = write_data_q;
        write_reg_d   = write_reg_q;
        reg_write_d   = 1'b0;
        wb_valid_d    = 1'b0;
        mem_fault_d   = mem_fault_q;
        mem_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    addr_d        = ALUOut;
                    b_d           = B;
                    wreg_d        = WriteReg_in;
                    mem_read_d    = MemRead;
                    mem_write_d   = MemWrite;
                    memtoreg_d    = MemtoReg;
                    regwrite_in_d = RegWrite_in;
                    fault_d       = fault_now;
                    // Faulting or non-memory transactions skip the access wait entirely.
                    if (!mem_op || fault_now) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_W'(ACCESS_LAT - 1);
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    mem_we = mem_write_q && !fault_q;
                    if (mem_read_q) begin
                        load_d = mem_rdata;
                    end
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                wb_valid_d   = 1'b1;
                reg_write_d  = regwrite_in_q && !fault_q;
                write_data_d = fault_q ? 32'd0 : (memtoreg_q ? load_q : addr_q);
                write_reg_d  = wreg_q;
                mem_fault_d  = fault_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            b_q           <= '0;
            wreg_q        <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            memtoreg_q    <= 1'b0;
            regwrite_in_q <= 1'b0;
            fault_q       <= 1'b0;
            load_q        <= '0;
            write_data_q  <= '0;
            write_reg_q   <= '0;
            reg_write_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            mem_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            b_q           <= b_d;
            wreg_q        <= wreg_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            memtoreg_q    <= memtoreg_d;
            regwrite_in_q <= regwrite_in_d;
            fault_q       <= fault_d;
            load_q        <= load_d;
            write_data_q  <= write_data_d;
            write_reg_q   <= write_reg_d;
            reg_write_q   <= reg_write_d;
            wb_valid_q    <= wb_valid_d;
            mem_fault_q   <= mem_fault_d;
        end
    end

    assign WriteData = write_data_q;
    assign WriteReg  = write_reg_q;
    assign RegWrite  = reg_write_q;
    assign wb_valid  = wb_valid_q;
    assign mem_fault = mem_fault_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: writeback timing, LW/SW round trips, faults,
// backpressure and reset behaviour, checked with immediate assertions.
module tb_data_mem_stage;
    import data_mem_stage_pkg::*;

    logic         CLK;
    logic         RESET;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  ALUOut;
    logic [31:0]  B;
    logic [4:0]   WriteReg_in;
    logic         MemRead;
    logic         MemWrite;
    logic         MemtoReg;
    logic         RegWrite_in;
    logic [31:0]  WriteData;
    logic [4:0]   WriteReg;
    logic         RegWrite;
    logic         wb_valid;
    logic         mem_fault;
    stage_state_e state_dbg;

    int total = 0;
    int bad   = 0;

    data_mem_stage #(
        .MEM_BYTES  (1024),
        .ACCESS_LAT (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOut      (ALUOut),
        .B           (B),
        .WriteReg_in (WriteReg_in),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite_in (RegWrite_in),
        .WriteData   (WriteData),
        .WriteReg    (WriteReg),
        .RegWrite    (RegWrite),
        .wb_valid    (wb_valid),
        .mem_fault   (mem_fault),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] bval, input logic [4:0] wr,
                         input logic mr, input logic mw, input logic m2r, input logic rw);
        ALUOut      = alu;
        B           = bval;
        WriteReg_in = wr;
        MemRead     = mr;
        MemWrite    = mw;
        MemtoReg    = m2r;
        RegWrite_in = rw;
        in_valid    = 1'b1;
    endtask

    // Issue one transaction, return cycles from accept edge to wb_valid and the writeback fields.
    task automatic txn(input string tag, input logic [31:0] alu, input logic [31:0] bval,
                       input logic [4:0] wr, input logic mr, input logic mw, input logic m2r,
                       input logic rw, output int lat, output logic [31:0] wd,
                       output logic [4:0] wrg, output logic rgw, output logic flt);
        @(negedge CLK);
        drive(alu, bval, wr, mr, mw, m2r, rw);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK);
            #1 lat++;
        end while (!wb_valid && lat < 20);
        wd  = WriteData;
        wrg = WriteReg;
        rgw = RegWrite;
        flt = mem_fault;
        @(posedge CLK);
        #1 chk({tag, "_wb_pulse_end"}, 32'(wb_valid), 32'd0);
    endtask

    int          lat;
    logic [31:0] wd;
    logic [4:0]  wrg;
    logic        rgw;
    logic        flt;
    int          wb_seen;

    initial begin
        RESET       = 1'b1;
        in_valid    = 1'b0;
        ALUOut      = '0;
        B           = '0;
        WriteReg_in = '0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite_in = 1'b0;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wd", WriteData, 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rel_ready", 32'(in_ready), 32'd1);

        // R-type writeback
        txn("rtype", 32'h7, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, lat, wd, wrg, rgw, flt);
        chk("rtype_lat", 32'(lat), 32'd1);
        chk("rtype_wd", wd, 32'h7);
        chk("rtype_wr", 32'(wrg), 32'd2);
        chk("rtype_rw", 32'(rgw), 32'd1);
        chk("rtype_flt", 32'(flt), 32'd0);

        // SW then LW
        txn("sw10", 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, wd, wrg, rgw, flt);
        chk("sw10_lat", 32'(lat), 32'd3);
        chk("sw10_rw", 32'(rgw), 32'd0);
        chk("sw10_flt", 32'(flt), 32'd0);
        txn("lw10", 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("lw10_lat", 32'(lat), 32'd3);
        chk("lw10_wd", wd, 32'hDEADBEEF);
        chk("lw10_wr", 32'(wrg), 32'd5);
        chk("lw10_rw", 32'(rgw), 32'd1);

        // last word in range; SW with RegWrite writes back the address
        txn("sw3fc", 32'h3FC, 32'h0BADC0DE, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, lat, wd, wrg, rgw, flt);
        chk("sw3fc_rw", 32'(rgw), 32'd1);
        chk("sw3fc_wd", wd, 32'h3FC);
        txn("lw3fc", 32'h3FC, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("lw3fc_wd", wd, 32'h0BADC0DE);

        // faults
        txn("mis", 32'h12, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_flt", 32'(flt), 32'd1);
        chk("mis_rw", 32'(rgw), 32'd0);
        chk("mis_wd", wd, 32'd0);
        txn("oor", 32'h400, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("oor_flt", 32'(flt), 32'd1);
        chk("oor_lat", 32'(lat), 32'd1);
        txn("both", 32'h10, 32'h55555555, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("both_flt", 32'(flt), 32'd1);
        txn("both_rb", 32'h10, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("both_rb_wd", wd, 32'hDEADBEEF);
        chk("both_rb_flt", 32'(flt), 32'd0);

        // backpressure: in_valid held with shifting inputs during ACCESS/WB
        @(negedge CLK);
        drive(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("bp_ready_first", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_ready_busy", 32'(in_ready), 32'd0);
            chk("bp_no_wb", 32'(wb_valid), 32'd0);
            drive(32'h100 + 32'(i * 4), 32'hFFFF0000, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        @(negedge CLK);
        chk("bp_wb", 32'(wb_valid), 32'd1);
        chk("bp_wd", WriteData, 32'hDEADBEEF);
        chk("bp_wr", 32'(WriteReg), 32'd5);
        chk("bp_ready_after", 32'(in_ready), 32'd1);
        drive(32'h99, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp2_not_yet", 32'(wb_valid), 32'd0);
        @(negedge CLK);
        chk("bp2_wb", 32'(wb_valid), 32'd1);
        chk("bp2_wd", WriteData, 32'h99);
        chk("bp2_wr", 32'(WriteReg), 32'd7);

        // mid-sim reset clears outputs
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("mrst_wd", WriteData, 32'd0);
        chk("mrst_wr", 32'(WriteReg), 32'd0);
        chk("mrst_rw", 32'(RegWrite), 32'd0);
        chk("mrst_flt", 32'(mem_fault), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("mrst_rel_ready", 32'(in_ready), 32'd1);

        // reset during SW access must not commit
        txn("sw20", 32'h20, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, wd, wrg, rgw, flt);
        @(negedge CLK);
        drive(32'h20, 32'h11223344, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        chk("swrst_in_access", 32'(state_dbg), 32'(ST_ACCESS));
        #1 RESET = 1'b1;
        #1 chk("swrst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge CLK);
        RESET = 1'b0;
        wb_seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (wb_valid) wb_seen++;
        end
        chk("swrst_no_wb", 32'(wb_seen), 32'd0);
        txn("lw20", 32'h20, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("lw20_wd", wd, 32'hCAFEF00D);
        txn("lw10_end", 32'h10, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, lat, wd, wrg, rgw, flt);
        chk("lw10_end_wd", wd, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
